aes_key_sched: RTL and testbench

- Iterative AES-128 key-expansion unit that sits directly upstream of the per-round datapath.
- Accepts a 128-bit cipher key over a valid/ready handshake and generates round keys 0..10, one per clock.
- Stores all round keys in an internal 11-entry register file.
- Serves keys through a registered indexed read port that the round controller uses to drive each round's key input.

---
 rtl/aes_key_sched.sv | 153 +++++++++++++++
 tb/tb_aes_key_sched.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_sched.sv
// Iterative AES-128 key expansion: one round key per clock into an 11-entry
// register file, served through a registered indexed read port.

module aes_sbox (
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0), then the affine transform.
    function automatic logic [7:0] sbox_byte(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240, v;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        v    = gf_mul(gf_mul(x240, x12), x2);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_byte
        assign o_word[8*g +: 8] = sbox_byte(i_word[8*g +: 8]);
    end
endmodule

module aes_key_sched #(
    parameter int unsigned RND_SIZE = 128,
    parameter int unsigned WRD_SIZE = 32,
    parameter int unsigned NUM_RND  = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_key_vld,
    input  logic [RND_SIZE-1:0] i_key,
    output logic                o_key_rdy,
    output logic                o_busy,
    output logic                o_sched_done,
    input  logic                i_rd_en,
    input  logic [3:0]          i_rd_idx,
    output logic [RND_SIZE-1:0] o_rnd_key,
    output logic                o_rd_err
);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

    state_t              r_state;
    logic [RND_SIZE-1:0] r_ent [0:NUM_RND];
    logic [RND_SIZE-1:0] r_wkey;
    logic [CNT_W-1:0]    r_cnt;
    logic [7:0]          r_rcon;

    logic [WRD_SIZE-1:0] w_w0, w_w1, w_w2, w_w3;
    logic [WRD_SIZE-1:0] w_rot, w_sub, w_t;
    logic [WRD_SIZE-1:0] w_n0, w_n1, w_n2, w_n3;
    logic [RND_SIZE-1:0] w_next;
    logic                w_load;

    // Next round key from the working key.
    assign {w_w0, w_w1, w_w2, w_w3} = r_wkey;
    assign w_rot  = {w_w3[WRD_SIZE-9:0], w_w3[WRD_SIZE-1 -: 8]};
    assign w_t    = w_sub ^ (WRD_SIZE'(r_rcon) << (WRD_SIZE - 8));
    assign w_n0   = w_w0 ^ w_t;
    assign w_n1   = w_w1 ^ w_n0;
    assign w_n2   = w_w2 ^ w_n1;
    assign w_n3   = w_w3 ^ w_n2;
    assign w_next = {w_n0, w_n1, w_n2, w_n3};
    assign w_load = i_key_vld & o_key_rdy;

    aes_sbox u_sbox (
        .i_word (w_rot),
        .o_word (w_sub)
    );

    // Control FSM, round-key storage and working key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            o_key_rdy    <= 1'b1;
            o_busy       <= 1'b0;
            o_sched_done <= 1'b0;
            r_wkey       <= '0;
            r_cnt        <= '0;
            r_rcon       <= 8'h01;
            for (int i = 0; i <= int'(NUM_RND); i++) r_ent[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_load) begin
                        r_ent[0]     <= i_key;
                        r_wkey       <= i_key;
                        r_cnt        <= CNT_W'(1);
                        r_rcon       <= 8'h01;
                        o_sched_done <= 1'b0;
                        o_key_rdy    <= 1'b0;
                        o_busy       <= 1'b1;
                        r_state      <= S_EXPAND;
                    end
                end
                S_EXPAND: begin
                    r_ent[r_cnt] <= w_next;
                    r_wkey       <= w_next;
                    r_cnt        <= r_cnt + CNT_W'(1);
                    r_rcon       <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1B : 8'h00);
                    if (r_cnt == CNT_W'(NUM_RND)) begin
                        o_sched_done <= 1'b1;
                        o_key_rdy    <= 1'b1;
                        o_busy       <= 1'b0;
                        r_state      <= S_DONE;
                    end
                end
                default: begin
                    o_key_rdy <= 1'b1;
                    o_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    // Registered read port; out-of-range index returns zero with an error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rnd_key <= '0;
            o_rd_err  <= 1'b0;
        end else if (i_rd_en) begin
            if (i_rd_idx <= CNT_W'(NUM_RND)) begin
                o_rnd_key <= r_ent[i_rd_idx];
                o_rd_err  <= 1'b0;
            end else begin
                o_rnd_key <= '0;
                o_rd_err  <= 1'b1;
            end
        end else begin
            o_rd_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_aes_key_sched.sv
// Directed bench for aes_key_sched using FIPS-197 AES-128 key schedules.

module tb_aes_key_sched;
    logic         clk;
    logic         rst_n;
    logic         i_key_vld;
    logic [127:0] i_key;
    logic         o_key_rdy;
    logic         o_busy;
    logic         o_sched_done;
    logic         i_rd_en;
    logic [3:0]   i_rd_idx;
    logic [127:0] o_rnd_key;
    logic         o_rd_err;

    int n_checks;
    int n_pass;

    logic [127:0] fips_rk [0:10];
    logic [127:0] key_a;
    logic [127:0] key_b;
    logic [127:0] key_b_rk10;

    aes_key_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_key_vld    (i_key_vld),
        .i_key        (i_key),
        .o_key_rdy    (o_key_rdy),
        .o_busy       (o_busy),
        .o_sched_done (o_sched_done),
        .i_rd_en      (i_rd_en),
        .i_rd_idx     (i_rd_idx),
        .o_rnd_key    (o_rnd_key),
        .o_rd_err     (o_rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [127:0] key);
        i_key     = key;
        i_key_vld = 1'b1;
        step();
        i_key_vld = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] idx);
        i_rd_en  = 1'b1;
        i_rd_idx = idx;
        step();
        i_rd_en  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if ({o_key_rdy, o_busy, o_sched_done, o_rd_err} !== 4'b1000)
            $display("FAIL reset_flags: got rdy/busy/done/err=%b expected 1000",
                     {o_key_rdy, o_busy, o_sched_done, o_rd_err});
        else n_pass++;
        n_checks++;
        if (o_rnd_key !== 128'h0) $display("FAIL reset_rnd_key: got %h expected 0", o_rnd_key);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        do_read(4'd0);
        n_checks++;
        if (o_rnd_key !== 128'h0) $display("FAIL reset_entry0: got %h expected 0", o_rnd_key);
        else n_pass++;
    endtask

    task automatic test_fips_expand();
        do_load(key_a);
        n_checks++;
        if ({o_key_rdy, o_busy, o_sched_done} !== 3'b010)
            $display("FAIL load_flags: got rdy/busy/done=%b expected 010",
                     {o_key_rdy, o_busy, o_sched_done});
        else n_pass++;
        for (int k = 1; k <= 10; k++) begin
            step();
            n_checks++;
            if (o_sched_done !== (k == 10))
                $display("FAIL done_timing: cycle %0d got done=%b expected %b", k, o_sched_done, (k == 10));
            else n_pass++;
        end
        n_checks++;
        if ({o_key_rdy, o_busy} !== 2'b10)
            $display("FAIL done_flags: got rdy/busy=%b expected 10", {o_key_rdy, o_busy});
        else n_pass++;
        foreach (fips_rk[i]) begin
            if (i == 0 || i == 1 || i == 2 || i == 10) begin
                do_read(4'(i));
                n_checks++;
                if (o_rnd_key !== fips_rk[i])
                    $display("FAIL fips_idx%0d: got %h expected %h", i, o_rnd_key, fips_rk[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        i_rd_en  = 1'b1;
        i_rd_idx = 4'd0;
        for (int k = 0; k <= 10; k++) begin
            step();
            n_checks++;
            if (o_rnd_key !== fips_rk[k])
                $display("FAIL b2b_idx%0d: got %h expected %h", k, o_rnd_key, fips_rk[k]);
            else n_pass++;
            if (k < 10) i_rd_idx = 4'(k + 1);
            else        i_rd_en  = 1'b0;
        end
        i_rd_idx = 4'd3;
        for (int k = 0; k < 3; k++) step();
        n_checks++;
        if (o_rnd_key !== fips_rk[10])
            $display("FAIL read_hold: got %h expected %h", o_rnd_key, fips_rk[10]);
        else n_pass++;
    endtask

    task automatic test_ignore_vld();
        do_load(key_a);
        for (int k = 1; k <= 3; k++) step();
        i_key     = 128'h0;
        i_key_vld = 1'b1;
        step();
        i_key_vld = 1'b0;
        n_checks++;
        if ({o_key_rdy, o_busy, o_sched_done} !== 3'b010)
            $display("FAIL ignore_flags: got rdy/busy/done=%b expected 010",
                     {o_key_rdy, o_busy, o_sched_done});
        else n_pass++;
        for (int k = 5; k <= 10; k++) step();
        n_checks++;
        if (o_sched_done !== 1'b1) $display("FAIL ignore_done: got %b expected 1", o_sched_done);
        else n_pass++;
        do_read(4'd4);
        n_checks++;
        if (o_rnd_key !== fips_rk[4])
            $display("FAIL ignore_idx4: got %h expected %h", o_rnd_key, fips_rk[4]);
        else n_pass++;
        do_read(4'd10);
        n_checks++;
        if (o_rnd_key !== fips_rk[10])
            $display("FAIL ignore_idx10: got %h expected %h", o_rnd_key, fips_rk[10]);
        else n_pass++;
    endtask

    task automatic test_rd_err();
        do_read(4'd11);
        n_checks++;
        if ({o_rd_err, o_rnd_key} !== {1'b1, 128'h0})
            $display("FAIL rd_err_11: got err=%b key=%h expected err=1 key=0", o_rd_err, o_rnd_key);
        else n_pass++;
        do_read(4'd15);
        n_checks++;
        if ({o_rd_err, o_rnd_key} !== {1'b1, 128'h0})
            $display("FAIL rd_err_15: got err=%b key=%h expected err=1 key=0", o_rd_err, o_rnd_key);
        else n_pass++;
        do_read(4'd10);
        n_checks++;
        if ({o_rd_err, o_rnd_key} !== {1'b0, fips_rk[10]})
            $display("FAIL rd_err_clear: got err=%b key=%h expected err=0 key=%h",
                     o_rd_err, o_rnd_key, fips_rk[10]);
        else n_pass++;
        do_read(4'd12);
        step();
        n_checks++;
        if (o_rd_err !== 1'b0) $display("FAIL rd_err_pulse: got %b expected 0", o_rd_err);
        else n_pass++;
    endtask

    task automatic test_reload();
        do_load(key_b);
        n_checks++;
        if ({o_sched_done, o_busy} !== 2'b01)
            $display("FAIL reload_start: got done/busy=%b expected 01", {o_sched_done, o_busy});
        else n_pass++;
        for (int k = 1; k <= 10; k++) begin
            step();
            n_checks++;
            if (o_sched_done !== (k == 10))
                $display("FAIL reload_timing: cycle %0d got done=%b expected %b", k, o_sched_done, (k == 10));
            else n_pass++;
        end
        do_read(4'd10);
        n_checks++;
        if (o_rnd_key !== key_b_rk10)
            $display("FAIL reload_idx10: got %h expected %h", o_rnd_key, key_b_rk10);
        else n_pass++;
        do_read(4'd0);
        n_checks++;
        if (o_rnd_key !== key_b)
            $display("FAIL reload_idx0: got %h expected %h", o_rnd_key, key_b);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int nz;
        do_read(4'd10);
        do_load(key_a);
        for (int k = 1; k <= 5; k++) step();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_key_rdy, o_busy, o_sched_done, o_rd_err} !== 4'b1000)
            $display("FAIL midrst_flags: got rdy/busy/done/err=%b expected 1000",
                     {o_key_rdy, o_busy, o_sched_done, o_rd_err});
        else n_pass++;
        n_checks++;
        if (o_rnd_key !== 128'h0) $display("FAIL midrst_rnd_key: got %h expected 0", o_rnd_key);
        else n_pass++;
        step();
        rst_n = 1'b1;
        nz = 0;
        for (int k = 0; k <= 10; k++) begin
            do_read(4'(k));
            if (o_rnd_key !== 128'h0) nz++;
        end
        n_checks++;
        if (nz !== 0) $display("FAIL midrst_entries: got %0d nonzero entries expected 0", nz);
        else n_pass++;
        n_checks++;
        if ({o_key_rdy, o_busy, o_sched_done} !== 3'b100)
            $display("FAIL midrst_idle: got rdy/busy/done=%b expected 100",
                     {o_key_rdy, o_busy, o_sched_done});
        else n_pass++;
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        i_key_vld  = 1'b0;
        i_key      = 128'h0;
        i_rd_en    = 1'b0;
        i_rd_idx   = 4'd0;
        key_a      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        key_b      = 128'h000102030405060708090a0b0c0d0e0f;
        key_b_rk10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        test_reset();
        test_fips_expand();
        test_back_to_back();
        test_ignore_vld();
        test_rd_err();
        test_reload();
        test_reset_mid();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
